cpu_register_file_mp: RTL and testbench

Parametrised successor to the CPU register file. It keeps the same combinational two-read/one-write datapath, and adds three things: configurable width and depth, same-cycle write-to-read bypass, and a sequencer. The sequencer runs a multi-cycle clear and a valid/ready register dump stream for debug/scan-out. It sits between decode (read addresses) and writeback (write port), with the dump stream feeding the debug UART/trace block.

---
 rtl/cpu_register_file_pkg.sv | 25 ++
 rtl/cpu_register_file_sequencer.sv | 126 ++++++++++++
 rtl/cpu_register_file_mp.sv | 133 +++++++++++++
 tb/tb_cpu_register_file_mp.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_register_file_pkg.sv
// ---------------------------------------------------------------------------
// cpu_register_file_pkg
// Shared definitions for the parametrised register file and its sequencer:
//   - seq_state_t           : sequencer state (IDLE / CLEAR / DUMP)
//   - DEFAULT_* localparams : default width and depth of the register file
//   - registerIndexWidth()  : number of bits needed to index the register file
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_register_file_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DUMP  = 2'd2
    } seq_state_t;

    localparam int DEFAULT_DATA_WIDTH          = 8;
    localparam int DEFAULT_NUMBER_OF_REGISTERS = 256;

    // A depth of one would give $clog2 of zero, so at least one index bit is kept.
    function automatic int registerIndexWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cpu_register_file_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_register_file_sequencer
// Runs the multi-cycle clear and the valid/ready dump stream of the register
// file. It owns the state, the single walking pointer and the dump snapshot.
// Ports:
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_clear_start             : request a sequential clear of every register
//   i_dump_start              : request a stream of every register
//   i_dump_ready              : consumer accepts the current beat
//   i_snapshot_data           : register value (write-bypass resolved) at
//                               o_snapshot_address, loaded into the snapshot
//   o_snapshot_address        : index whose value is loaded next
//   o_clear_active            : clear in progress (writes must be blocked)
//   o_clear_address           : register being zeroed this cycle
//   o_busy                    : sequencer is in CLEAR or DUMP
//   o_dump_valid/_address/_data/_last : current dump beat
// ---------------------------------------------------------------------------
module cpu_register_file_sequencer
    import cpu_register_file_pkg::*;
#(
    parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
    parameter int NUMBER_OF_REGISTERS = DEFAULT_NUMBER_OF_REGISTERS,
    parameter int AW                  = registerIndexWidth(NUMBER_OF_REGISTERS)
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_clear_start,
    input  logic                         i_dump_start,
    input  logic                         i_dump_ready,
    input  logic signed [DATA_WIDTH-1:0] i_snapshot_data,
    output logic [AW-1:0]                o_snapshot_address,
    output logic                         o_clear_active,
    output logic [AW-1:0]                o_clear_address,
    output logic                         o_busy,
    output logic                         o_dump_valid,
    output logic [AW-1:0]                o_dump_address,
    output logic [DATA_WIDTH-1:0]        o_dump_data,
    output logic                         o_dump_last
);

    localparam logic [AW-1:0] LAST_INDEX = AW'(NUMBER_OF_REGISTERS - 1);

    seq_state_t                   r_state;
    seq_state_t                   w_nextState;
    logic [AW-1:0]                r_ptr;
    logic [AW-1:0]                w_nextPtr;
    logic                         w_loadSnapshot;
    logic                         w_atLast;
    logic signed [DATA_WIDTH-1:0] r_snapshot;

    // The pointer never wraps; the terminal entry is detected by comparison.
    assign w_atLast    = (r_ptr == LAST_INDEX);
    assign o_dump_data = r_snapshot;

    // State, pointer and snapshot registers. The snapshot only changes when a
    // new beat is loaded, so a held beat is immune to later writes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_snapshot <= '0;
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
            if (w_loadSnapshot) begin
                r_snapshot <= i_snapshot_data;
            end
        end
    end

    // Next-state logic. A clear request beats a simultaneous dump request, and
    // start requests are ignored outside IDLE. The next beat is fetched through
    // the write-bypass path so a write on the handshake edge is captured.
    always_comb begin
        w_nextState        = r_state;
        w_nextPtr          = r_ptr;
        w_loadSnapshot     = 1'b0;
        o_snapshot_address = r_ptr;
        case (r_state)
            IDLE: begin
                if (i_clear_start) begin
                    w_nextState = CLEAR;
                    w_nextPtr   = '0;
                end else if (i_dump_start) begin
                    w_nextState        = DUMP;
                    w_nextPtr          = '0;
                    w_loadSnapshot     = 1'b1;
                    o_snapshot_address = '0;
                end
            end
            CLEAR: begin
                if (w_atLast) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextPtr = r_ptr + AW'(1);
                end
            end
            DUMP: begin
                if (i_dump_ready) begin
                    if (w_atLast) begin
                        w_nextState = IDLE;
                    end else begin
                        w_nextPtr          = r_ptr + AW'(1);
                        w_loadSnapshot     = 1'b1;
                        o_snapshot_address = r_ptr + AW'(1);
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, so ready never reaches valid
    // combinationally. Beat address and last flag read zero outside DUMP.
    always_comb begin
        o_busy          = (r_state != IDLE);
        o_dump_valid    = (r_state == DUMP);
        o_dump_address  = (r_state == DUMP) ? r_ptr : '0;
        o_dump_last     = (r_state == DUMP) && w_atLast;
        o_clear_active  = (r_state == CLEAR);
        o_clear_address = r_ptr;
    end

endmodule

// File: rtl/cpu_register_file_mp.sv
// ---------------------------------------------------------------------------
// cpu_register_file_mp
// Parametrised two-read/one-write register file with same-cycle write-to-read
// bypass, optional hard-wired zero register, a sequential clear and a
// valid/ready debug dump stream.
// Ports:
//   clock_in, reset_in                   : clock, synchronous active-high reset
//   write_enable_in / write_register_address_in / write_data_in : write port
//   read_register_address{1,2}_in        : read addresses
//   read_data{1,2}_out                   : combinational read data
//   clear_start_in, dump_start_in        : one-cycle sequencer requests
//   busy_out                             : sequencer in CLEAR or DUMP
//   dump_valid_out / dump_ready_in       : dump handshake
//   dump_address_out / dump_data_out / dump_last_out : dump beat
// ---------------------------------------------------------------------------
module cpu_register_file_mp
    import cpu_register_file_pkg::*;
#(
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
    parameter int NUMBER_OF_REGISTERS  = DEFAULT_NUMBER_OF_REGISTERS,
    parameter int ZERO_REGISTER_ENABLE = 1,
    parameter int AW                   = registerIndexWidth(NUMBER_OF_REGISTERS)
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         write_enable_in,
    input  logic [AW-1:0]                write_register_address_in,
    input  logic signed [DATA_WIDTH-1:0] write_data_in,
    input  logic [AW-1:0]                read_register_address1_in,
    input  logic [AW-1:0]                read_register_address2_in,
    output logic signed [DATA_WIDTH-1:0] read_data1_out,
    output logic signed [DATA_WIDTH-1:0] read_data2_out,
    input  logic                         clear_start_in,
    input  logic                         dump_start_in,
    output logic                         busy_out,
    output logic                         dump_valid_out,
    input  logic                         dump_ready_in,
    output logic [AW-1:0]                dump_address_out,
    output logic [DATA_WIDTH-1:0]        dump_data_out,
    output logic                         dump_last_out
);

    logic signed [DATA_WIDTH-1:0] r_registers     [NUMBER_OF_REGISTERS];
    logic signed [DATA_WIDTH-1:0] w_debugRegister [NUMBER_OF_REGISTERS];

    logic                         w_writeAccept;
    logic                         w_clearActive;
    logic [AW-1:0]                w_clearAddress;
    logic [AW-1:0]                w_snapshotAddress;
    logic signed [DATA_WIDTH-1:0] w_snapshotData;

    // Register 0 is hard-wired only when the zero register is enabled.
    function automatic logic isZeroRegister(input logic [AW-1:0] address);
        return (ZERO_REGISTER_ENABLE != 0) && (address == '0);
    endfunction

    // Resolves one read: zero register first, then an accepted same-cycle
    // write to the same address, then the stored value.
    function automatic logic signed [DATA_WIDTH-1:0] resolveRead(
        input logic [AW-1:0]                address,
        input logic                         writeAccept,
        input logic [AW-1:0]                writeAddress,
        input logic signed [DATA_WIDTH-1:0] writeData,
        input logic signed [DATA_WIDTH-1:0] storedValue
    );
        if (isZeroRegister(address)) begin
            return '0;
        end else if (writeAccept && (writeAddress == address)) begin
            return writeData;
        end
        return storedValue;
    endfunction

    // Per-register debug view of the storage; all reads go through it.
    for (genvar g = 0; g < NUMBER_OF_REGISTERS; g++) begin : g_debug
        assign w_debugRegister[g] = r_registers[g];
    end

    // A write is dropped in the reset cycle, during a clear, and when it
    // targets the hard-wired zero register. Blocking it here also removes
    // the bypass in those cases.
    assign w_writeAccept = write_enable_in && !reset_in && !w_clearActive &&
                           !isZeroRegister(write_register_address_in);

    assign read_data1_out = resolveRead(read_register_address1_in, w_writeAccept,
                                        write_register_address_in, write_data_in,
                                        w_debugRegister[read_register_address1_in]);
    assign read_data2_out = resolveRead(read_register_address2_in, w_writeAccept,
                                        write_register_address_in, write_data_in,
                                        w_debugRegister[read_register_address2_in]);
    assign w_snapshotData = resolveRead(w_snapshotAddress, w_writeAccept,
                                        write_register_address_in, write_data_in,
                                        w_debugRegister[w_snapshotAddress]);

    // Storage array. Clear and write never coincide because writes are
    // blocked for the whole clear.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                r_registers[i] <= '0;
            end
        end else begin
            if (w_clearActive) begin
                r_registers[w_clearAddress] <= '0;
            end
            if (w_writeAccept) begin
                r_registers[write_register_address_in] <= write_data_in;
            end
        end
    end

    cpu_register_file_sequencer #(
        .DATA_WIDTH          (DATA_WIDTH),
        .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS),
        .AW                  (AW)
    ) u_sequencer (
        .i_clock            (clock_in),
        .i_reset            (reset_in),
        .i_clear_start      (clear_start_in),
        .i_dump_start       (dump_start_in),
        .i_dump_ready       (dump_ready_in),
        .i_snapshot_data    (w_snapshotData),
        .o_snapshot_address (w_snapshotAddress),
        .o_clear_active     (w_clearActive),
        .o_clear_address    (w_clearAddress),
        .o_busy             (busy_out),
        .o_dump_valid       (dump_valid_out),
        .o_dump_address     (dump_address_out),
        .o_dump_data        (dump_data_out),
        .o_dump_last        (dump_last_out)
    );

endmodule

// File: tb/tb_cpu_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_cpu_register_file_mp
// Bench for an 8-entry, 8-bit register file with the zero register enabled.
// A behavioural model tracks register contents and the current activity
// (idle / clearing / dumping); a negedge process compares every output with
// it each cycle. Directed scenarios add literal expectations, then a
// randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_cpu_register_file_mp;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 3;

    localparam int ACT_IDLE  = 0;
    localparam int ACT_CLEAR = 1;
    localparam int ACT_DUMP  = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 writeEnable;
    logic [AW-1:0]        writeAddress;
    logic signed [DW-1:0] writeData;
    logic [AW-1:0]        readAddress1;
    logic [AW-1:0]        readAddress2;
    logic signed [DW-1:0] readData1;
    logic signed [DW-1:0] readData2;
    logic                 clearStart;
    logic                 dumpStart;
    logic                 busy;
    logic                 dumpValid;
    logic                 dumpReady;
    logic [AW-1:0]        dumpAddress;
    logic [DW-1:0]        dumpData;
    logic                 dumpLast;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] model [N];
    int         activity;
    int         walkIndex;
    logic [7:0] heldBeat;
    bit         modelReady = 1'b0;

    typedef struct {
        int addr;
        int data;
        bit last;
    } beat_t;
    beat_t beatLog[$];

    int busyCycles;
    int validCycles;

    cpu_register_file_mp #(
        .DATA_WIDTH           (DW),
        .NUMBER_OF_REGISTERS  (N),
        .ZERO_REGISTER_ENABLE (1)
    ) dut (
        .clock_in                  (clock),
        .reset_in                  (reset),
        .write_enable_in           (writeEnable),
        .write_register_address_in (writeAddress),
        .write_data_in             (writeData),
        .read_register_address1_in (readAddress1),
        .read_register_address2_in (readAddress2),
        .read_data1_out            (readData1),
        .read_data2_out            (readData2),
        .clear_start_in            (clearStart),
        .dump_start_in             (dumpStart),
        .busy_out                  (busy),
        .dump_valid_out            (dumpValid),
        .dump_ready_in             (dumpReady),
        .dump_address_out          (dumpAddress),
        .dump_data_out             (dumpData),
        .dump_last_out             (dumpLast)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Single comparison point; every check of the bench passes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle's worth of inputs; called just after a rising edge.
    task automatic applyStimulus(input logic rst, input logic we, input int wa,
                                 input int wd, input int a1, input int a2,
                                 input logic clr, input logic dmp, input logic rdy);
        reset        = rst;
        writeEnable  = we;
        writeAddress = AW'(wa);
        writeData    = DW'(wd);
        readAddress1 = AW'(a1);
        readAddress2 = AW'(a2);
        clearStart   = clr;
        dumpStart    = dmp;
        dumpReady    = rdy;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Expected combinational read: r0 is always zero; a write that the file
    // would accept this cycle is seen immediately; otherwise the stored value.
    function automatic logic [7:0] expectRead(input logic [AW-1:0] addr);
        if (addr == 0) return 8'h00;
        if (writeEnable && !reset && activity != ACT_CLEAR && writeAddress == addr)
            return 8'(writeData);
        return model[addr];
    endfunction

    // Behavioural model, advanced with the inputs seen at each rising edge.
    // Activities: a clear zeroes one entry per cycle for N cycles; a dump
    // presents one beat per entry, each beat holding the register contents
    // as they stood right after the edge that selected it.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) model[i] = 8'h00;
            activity   = ACT_IDLE;
            walkIndex  = 0;
            heldBeat   = 8'h00;
            modelReady = 1'b1;
        end else if (modelReady) begin
            int  snapIndex;
            bit  writeOk;
            snapIndex = -1;
            writeOk   = writeEnable && activity != ACT_CLEAR && writeAddress != 0;
            if (activity == ACT_IDLE) begin
                if (clearStart) begin
                    activity  = ACT_CLEAR;
                    walkIndex = 0;
                end else if (dumpStart) begin
                    activity  = ACT_DUMP;
                    walkIndex = 0;
                    snapIndex = 0;
                end
            end else if (activity == ACT_CLEAR) begin
                model[walkIndex] = 8'h00;
                if (walkIndex == N - 1) activity = ACT_IDLE;
                else walkIndex++;
            end else if (dumpReady) begin
                if (walkIndex == N - 1) activity = ACT_IDLE;
                else begin
                    walkIndex++;
                    snapIndex = walkIndex;
                end
            end
            if (writeOk) model[writeAddress] = 8'(writeData);
            if (snapIndex >= 0) heldBeat = model[snapIndex];
        end
    end

    // Compares every output against the model in the middle of each cycle
    // and records completed dump handshakes for the directed scenarios.
    always @(negedge clock) begin
        if (modelReady) begin
            checkOutput("read1", 32'($unsigned(readData1)), 32'(expectRead(readAddress1)));
            checkOutput("read2", 32'($unsigned(readData2)), 32'(expectRead(readAddress2)));
            checkOutput("busy", 32'(busy), 32'(activity != ACT_IDLE));
            checkOutput("dump_valid", 32'(dumpValid), 32'(activity == ACT_DUMP));
            checkOutput("dump_last", 32'(dumpLast),
                        32'(activity == ACT_DUMP && walkIndex == N - 1));
            if (activity == ACT_DUMP) begin
                checkOutput("dump_addr", 32'(dumpAddress), 32'(walkIndex));
                checkOutput("dump_data", 32'(dumpData), 32'(heldBeat));
            end
            if (dumpValid && dumpReady && !reset)
                beatLog.push_back('{int'(dumpAddress), int'(dumpData), dumpLast});
        end
    end

    task automatic fillRegisters();
        for (int r = 1; r < N; r++) begin
            applyStimulus(0, 1, r, r, 0, 0, 0, 0, 0);
            nextCycle();
        end
    endtask

    task automatic readAllExpectZero(input string name);
        for (int r = 0; r < N; r++) begin
            applyStimulus(0, 0, 0, 0, r, N - 1 - r, 0, 0, 0);
            @(negedge clock);
            checkOutput(name, 32'($unsigned(readData1)), 32'h0);
            nextCycle();
        end
    endtask

    task automatic checkBeatLog(input string name, input int count);
        checkOutput({name, "_count"}, 32'(beatLog.size()), 32'(count));
        for (int i = 0; i < beatLog.size() && i < count; i++) begin
            checkOutput({name, "_addr"}, 32'(beatLog[i].addr), 32'(i));
            checkOutput({name, "_data"}, 32'(beatLog[i].data), 32'(i));
            checkOutput({name, "_last"}, 32'(beatLog[i].last), 32'(i == N - 1));
        end
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_valid", 32'(dumpValid), 32'h0);
        checkOutput("reset_dump_data", 32'(dumpData), 32'h0);
        nextCycle();

        // Same-cycle bypass, then stored value, then zero register ignoring writes.
        applyStimulus(0, 1, 3, 'h5A, 3, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("bypass_r3", 32'($unsigned(readData1)), 32'h5A);
        nextCycle();
        applyStimulus(0, 1, 0, 'h11, 3, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("stored_r3", 32'($unsigned(readData1)), 32'h5A);
        checkOutput("r0_no_bypass", 32'($unsigned(readData2)), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("r0_after_write", 32'($unsigned(readData2)), 32'h0);
        nextCycle();

        // Sequential clear with a write to r5 attempted mid-clear.
        fillRegisters();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        nextCycle();
        busyCycles = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, i == 3, 5, 'h33, 5, 7, 0, 0, 0);
            @(negedge clock);
            if (busy) busyCycles++;
            if (i == 3) checkOutput("clear_r5_no_bypass", 32'($unsigned(readData1)), 32'h5);
            nextCycle();
        end
        checkOutput("clear_busy_cycles", 32'(busyCycles), 32'd8);
        readAllExpectZero("after_clear");

        // Full-speed dump.
        fillRegisters();
        beatLog.delete();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        nextCycle();
        busyCycles = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 2, 0, 0, 1);
            @(negedge clock);
            if (busy) busyCycles++;
            nextCycle();
        end
        checkOutput("dump_busy_cycles", 32'(busyCycles), 32'd8);
        checkBeatLog("dump_fast", N);

        // Back-pressure on beat 2 while r2 is overwritten.
        beatLog.delete();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        nextCycle();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, i == 2, 2, 'h77, 2, 4, 0, 0, !(i >= 2 && i <= 4));
            @(negedge clock);
            if (i == 3 || i == 4) begin
                checkOutput("held_beat_data", 32'(dumpData), 32'h2);
                checkOutput("held_beat_addr", 32'(dumpAddress), 32'h2);
            end
            nextCycle();
        end
        checkBeatLog("dump_stall", N);

        // Simultaneous clear and dump requests: the clear wins.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
        nextCycle();
        busyCycles  = 0;
        validCycles = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 0, 0, 2, 6, 0, 0, 1);
            @(negedge clock);
            if (busy) busyCycles++;
            if (dumpValid) validCycles++;
            nextCycle();
        end
        checkOutput("both_start_busy", 32'(busyCycles), 32'd8);
        checkOutput("both_start_valid", 32'(validCycles), 32'd0);
        readAllExpectZero("after_both_start");

        // Reset while beat 4 is on the stream; a write in that cycle is dropped.
        fillRegisters();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 4, i == 4, 6, 'h66, 6, 1, 0, 0, 1);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 6, 1, 0, 0, 0);
        @(negedge clock);
        checkOutput("mid_reset_busy", 32'(busy), 32'h0);
        checkOutput("mid_reset_valid", 32'(dumpValid), 32'h0);
        checkOutput("mid_reset_addr", 32'(dumpAddress), 32'h0);
        checkOutput("mid_reset_data", 32'(dumpData), 32'h0);
        checkOutput("mid_reset_last", 32'(dumpLast), 32'h0);
        nextCycle();
        readAllExpectZero("after_mid_reset");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, N - 1)),
                          int'($urandom_range(0, 255)),
                          int'($urandom_range(0, N - 1)),
                          int'($urandom_range(0, N - 1)),
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7);
            nextCycle();
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
